// File: rtl/vend_pkg.sv
// Shared types and coin values for the vend_credit controller.
package vend_pkg;

  // Controller states: accepting coins, one-cycle dispense, paying out change.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } vend_state_t;

  // Coin denominations in cents.
  localparam int NICKEL_C  = 5;
  localparam int DIME_C    = 10;
  localparam int QUARTER_C = 25;

endpackage

// File: rtl/vend_credit.sv
// Coin-operated vending controller with an accumulating credit register,
// configurable price, dime/nickel change return and cancel/refund.
module vend_credit
  import vend_pkg::*;
#(
  parameter int PRICE    = 15,
  parameter int CREDIT_W = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                N,
  input  logic                D,
  input  logic                Q,
  input  logic                cancel,
  input  logic                chg_ack,
  output logic                Open,
  output logic                chg_N,
  output logic                chg_D,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  // Reject illegal parameterisations at elaboration.
  if ((PRICE % 5) != 0 || PRICE < 5) begin : g_bad_price
    $error("vend_credit: PRICE must be a positive multiple of 5");
  end
  if ((64'd1 << CREDIT_W) <= 64'(PRICE + 20)) begin : g_bad_width
    $error("vend_credit: CREDIT_W too narrow for PRICE + 20");
  end

  localparam logic [CREDIT_W-1:0] PRICE_V   = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] NICKEL_V  = CREDIT_W'(NICKEL_C);
  localparam logic [CREDIT_W-1:0] DIME_V    = CREDIT_W'(DIME_C);
  localparam logic [CREDIT_W-1:0] QUARTER_V = CREDIT_W'(QUARTER_C);

  vend_state_t         state;
  vend_state_t         state_next;
  logic [CREDIT_W-1:0] credit_next;
  logic [CREDIT_W-1:0] coin_value;
  logic                coin_any;
  logic                coin_one;
  logic                reject_next;
  logic                want_dime;
  logic                want_nickel;

  // Decode the coin inputs: any activity, exactly-one-hot, and its value.
  always_comb begin
    coin_any   = N | D | Q;
    coin_one   = 1'b0;
    coin_value = '0;
    case ({N, D, Q})
      3'b100: begin coin_one = 1'b1; coin_value = NICKEL_V;  end
      3'b010: begin coin_one = 1'b1; coin_value = DIME_V;    end
      3'b001: begin coin_one = 1'b1; coin_value = QUARTER_V; end
      default: begin coin_one = 1'b0; coin_value = '0;       end
    endcase
  end

  // Change-coin selector: largest coin that fits the remaining credit.
  always_comb begin
    want_dime   = 1'b0;
    want_nickel = 1'b0;
    if (state == CHANGE) begin
      if (credit >= DIME_V) begin
        want_dime = 1'b1;
      end else if (credit >= NICKEL_V) begin
        want_nickel = 1'b1;
      end else begin
        want_nickel = 1'b0;
      end
    end else begin
      want_dime = 1'b0;
    end
  end

  // Next state, next credit and whether last cycle's coin was refused.
  always_comb begin
    state_next  = state;
    credit_next = credit;
    reject_next = 1'b0;
    case (state)
      IDLE: begin
        if (cancel) begin
          // Cancel always wins over a simultaneous coin.
          reject_next = coin_any;
          if (credit != '0) begin
            state_next = CHANGE;
          end else begin
            state_next = IDLE;
          end
        end else if (coin_one) begin
          credit_next = credit + coin_value;
          if (credit_next >= PRICE_V) begin
            state_next = VEND;
          end else begin
            state_next = IDLE;
          end
        end else begin
          reject_next = coin_any;
        end
      end
      VEND: begin
        reject_next = coin_any;
        credit_next = credit - PRICE_V;
        if (credit_next != '0) begin
          state_next = CHANGE;
        end else begin
          state_next = IDLE;
        end
      end
      CHANGE: begin
        reject_next = coin_any;
        if (chg_ack) begin
          if (want_dime) begin
            credit_next = credit - DIME_V;
          end else if (want_nickel) begin
            credit_next = credit - NICKEL_V;
          end else begin
            credit_next = credit;
          end
          if (credit_next == '0) begin
            state_next = IDLE;
          end else begin
            state_next = CHANGE;
          end
        end else begin
          state_next = CHANGE;
        end
      end
      default: begin
        state_next  = IDLE;
        credit_next = '0;
      end
    endcase
  end

  // State, credit and the registered Open / coin_reject strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      credit      <= '0;
      Open        <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_next;
      credit      <= credit_next;
      Open        <= (state_next == VEND);
      coin_reject <= reject_next;
    end
  end

  assign chg_D = want_dime;
  assign chg_N = want_nickel;
  assign busy  = (state != IDLE);

endmodule

// File: doc/vend_credit.md
# vend_credit

Parametrised coin-operated vending controller with an accumulating credit register, configurable price, change return and cancel/refund. It sits between the coin-acceptor front end (one-cycle coin pulses N/D/Q) and the dispense/change-hopper actuators. It succeeds the fixed 15¢ vend-only machine with these additions:

- arbitrary price;
- credit above price is returned as dime/nickel change through a ready/ack handshake;
- coins are rejected explicitly while busy.

## Interface
Parameters:
- PRICE, 15: item price in cents. Must be a multiple of 5 and ≥ 5.
- CREDIT_W, 7: credit register width. Must satisfy 2^CREDIT_W > PRICE + 20.

Ports (reset polarity and synchronicity are already decided):
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-low. reset=0 at a posedge resets the block.
- N  input  1  nickel pulse (5¢).
- D  input  1  dime pulse (10¢).
- Q  input  1  quarter pulse (25¢).
- cancel  input  1  refund request; honoured only in IDLE.
- chg_ack  input  1  change hopper has dropped the coin currently requested.
- Open  output  1  registered dispense strobe, exactly one cycle per vend.
- chg_N  output  1  request: drop one nickel of change; held until acknowledged.
- chg_D  output  1  request: drop one dime of change; held until acknowledged.
- coin_reject  output  1  registered one-cycle pulse: the coin presented last cycle was not credited.
- credit  output  CREDIT_W  current credit in cents.
- busy  output  1  high when state ≠ IDLE.

## Operation
States: IDLE, VEND, CHANGE.

IDLE
- A legal coin (exactly one of N/D/Q high): credit ← credit + value.
- If the new credit ≥ PRICE, go to VEND; otherwise stay in IDLE.
- cancel with credit > 0: go to CHANGE (refund). No Open is issued.
- cancel with credit = 0: no effect.
- cancel and a coin in the same cycle: cancel wins, the coin is rejected.

VEND (always exactly one cycle)
- Open = 1.
- credit ← credit − PRICE.
- Next state is CHANGE if the remainder > 0, otherwise IDLE.

CHANGE
- chg_D = 1 when credit ≥ 10, else chg_N = 1 when credit ≥ 5.
- chg_D and chg_N are never high together.
- On chg_ack: credit ← credit − 10 (for a dime) or − 5 (for a nickel).
- When credit reaches 0, go to IDLE.
- chg_ack outside CHANGE is ignored.

Coin rejection
- Any coin input in VEND or CHANGE is rejected.
- Any multi-hot N/D/Q combination in any state is rejected.
- A rejected coin leaves credit unchanged and sets coin_reject = 1 on the next cycle.

Arithmetic
- Credit is unsigned, CREDIT_W bits.
- Maximum reachable credit is PRICE + 20, so the parameter rule guarantees no overflow.
- All change amounts are multiples of 5, so credit never goes negative.

Reset
- Values: state = IDLE, credit = 0, Open = 0, chg_N = chg_D = 0, coin_reject = 0, busy = 0.
- Reset asserted in the middle of CHANGE abandons the remaining change. This is intended; power-up credit is lost.

## Timing
- Coin pulse at posedge k: credit updated at k+1. If the price is reached, state = VEND and Open = 1 during cycle k+1.
  - Vend latency is 1 cycle from coin to Open; Open is not combinational from the coin inputs.
- First change request appears at k+2 (the cycle after VEND).
- Change handshake: a request is sampled with chg_ack at each posedge.
  - Ack at posedge m: credit is decremented at m. The next request (or its deassertion) is visible in cycle m+1.
  - One coin per ack; an ack held high drains one coin per cycle.
- coin_reject asserts the cycle after the offending coin, for one cycle.
- busy is decoded from the state register.

## Structure
- Package vend_pkg holds:
  - state enum vend_state_t {IDLE, VEND, CHANGE};
  - coin constants NICKEL_C = 5, DIME_C = 10, QUARTER_C = 25.
- Single module, with:
  - a next-state/next-credit always_comb;
  - one always_ff for state, credit, Open and coin_reject.
- No sub-module is required. The change-coin selector is a few lines of combinational logic.
- Parameter legality is checked with elaboration-time assertions.

## Test plan
- Defaults. Coin sequence N, D: credit 5 then 15 → Open pulses one cycle, credit → 0, no change requested, back to IDLE.
- Defaults. Coins D, Q: credit 35 → Open.
  - Remainder 20: chg_D, ack → chg_D, ack → IDLE with credit 0.
  - Exactly 2 acks are consumed.
- Defaults. Coin N then cancel → chg_N held for 5 cycles without ack, then ack → IDLE. Open never asserts.
- PRICE=40, CREDIT_W=7. Coins Q, D, D: credit 45 → Open, chg_N once, then IDLE. A Q inserted during CHANGE → coin_reject pulse, credit unchanged.
- {N,D}=11 in IDLE → coin_reject, credit unchanged. cancel plus N in the same cycle with credit 10 → refund of 10, N rejected.
- Reset: reset=0 during CHANGE with credit 20 → next cycle all outputs take their reset values, credit = 0, chg_D low.
